// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and defaults for the keypad event queue
package keypad_pkg;

  // Debouncer FSM states
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } kp_state_e;

  // Queued event word: {press, code[3:0]}
  localparam int KP_EVT_W = 5;

  typedef struct packed {
    logic       press;
    logic [3:0] code;
  } kp_evt_t;

  localparam int KP_DEBOUNCE_CYCLES = 500000;
  localparam int KP_FIFO_DEPTH      = 4;

  function automatic kp_evt_t kp_make_evt(input logic press, input logic [3:0] code);
    kp_evt_t e;
    e.press = press;
    e.code  = code;
    return e;
  endfunction

endpackage

// File: rtl/keypad_event_queue_if.sv
// rtl/keypad_event_queue_if.sv - valid/ready event stream toward the player control
interface keypad_event_queue_if;

  logic       evt_valid;
  logic       evt_ready;
  logic [3:0] evt_code;
  logic       evt_press;

  modport master (output evt_valid, output evt_code, output evt_press, input evt_ready);
  modport slave  (input evt_valid, input evt_code, input evt_press, output evt_ready);

endinterface

// File: rtl/key_evt_fifo.sv
// rtl/key_evt_fifo.sv - show-ahead FIFO of event words with count/full/empty
module key_evt_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = KP_FIFO_DEPTH,
  parameter int AW    = 2
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    push,
  input  kp_evt_t push_data,
  input  logic    pop,
  output kp_evt_t head,
  output logic [AW:0] count,
  output logic    full,
  output logic    empty
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [KP_EVT_W-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                do_pop;
  logic                do_push;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign do_push = push && (!full || do_pop);
  assign head    = kp_evt_t'(mem[rd_ptr]);

  // Storage write; contents are don't-care until counted, so no reset needed
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/keypad_event_queue.sv
// rtl/keypad_event_queue.sv - debounce keypad activity into queued press/release events
module keypad_event_queue
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KP_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 20,
  parameter int FIFO_DEPTH      = KP_FIFO_DEPTH,
  parameter int FIFO_AW         = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3:0]           key_val,
  input  logic                 key_down,
  keypad_event_queue_if.master evt,
  output logic [FIFO_AW:0]     fifo_count,
  output logic                 overflow
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]  key_val_m, key_val_s;
  logic        key_down_m, key_down_s;

  kp_state_e   state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]  cand, cand_nxt;
  logic        key_match;
  logic        push;
  kp_evt_t     push_evt;

  kp_evt_t     head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop_now;

  // Two-flop synchronizers: the scan decoder runs on derived clocks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_val_m  <= '0;
      key_val_s  <= '0;
      key_down_m <= 1'b0;
      key_down_s <= 1'b0;
    end else begin
      key_val_m  <= key_val;
      key_val_s  <= key_val_m;
      key_down_m <= key_down;
      key_down_s <= key_down_m;
    end
  end

  // Debouncer state, stability counter and candidate key registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cand  <= cand_nxt;
    end
  end

  assign key_match = key_down_s && (key_val_s == cand);

  // Next-state logic: wait for a stable key, emit press; wait for stable absence, emit release
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    push      = 1'b0;
    push_evt  = kp_make_evt(1'b0, cand);
    case (state)
      ST_IDLE: begin
        if (key_down_s) begin
          state_nxt = ST_PRESS_WAIT;
          cand_nxt  = key_val_s;
          cnt_nxt   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!key_down_s) begin
          state_nxt = ST_IDLE;
        end else if (key_val_s != cand) begin
          cand_nxt = key_val_s;
          cnt_nxt  = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_HELD;
          push      = 1'b1;
          push_evt  = kp_make_evt(1'b1, cand);
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_HELD: begin
        if (!key_match) begin
          state_nxt = ST_RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (key_match) begin
          state_nxt = ST_HELD;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_IDLE;
          push      = 1'b1;
          push_evt  = kp_make_evt(1'b0, cand);
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  key_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_evt),
    .pop       (evt.evt_ready),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Outputs read 0 whenever the queue is empty, including throughout reset
  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_code  = fifo_empty ? 4'd0 : head.code;
  assign evt.evt_press = fifo_empty ? 1'b0 : head.press;
  assign pop_now       = !fifo_empty && evt.evt_ready;

  // Sticky overflow: an event arrived while full and nothing left the queue
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !pop_now) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_keypad_event_queue.sv
// tb/tb_keypad_event_queue.sv - self-checking bench for keypad_event_queue
module tb_keypad_event_queue;

  localparam int D     = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [3:0]       key_val;
  logic             key_down;
  logic [AW:0]      fifo_count;
  logic             overflow;

  keypad_event_queue_if evt_if ();

  keypad_event_queue #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (4),
    .FIFO_DEPTH      (DEPTH),
    .FIFO_AW         (AW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_val    (key_val),
    .key_down   (key_down),
    .evt        (evt_if),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: event queue, raw-input delay line, debounce run tracking
  logic [4:0] mq[$];
  logic       m_ovf;
  logic       r1_d, r2_d;
  logic [3:0] r1_v, r2_v;
  logic       m_held;
  logic [3:0] m_cand;
  int         m_run;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    r1_d   = 1'b0; r2_d = 1'b0;
    r1_v   = 4'd0; r2_v = 4'd0;
    m_held = 1'b0;
    m_cand = 4'd0;
    m_run  = 0;
  endtask

  // A press is D+1 consecutive samples of the same key down; a release is
  // D+1 consecutive samples where the held key is not seen down.
  task automatic model_edge();
    logic       s_d;
    logic [3:0] s_v;
    logic       pop;
    logic       has_evt;
    logic [4:0] ev;
    s_d = r2_d; s_v = r2_v;
    r2_d = r1_d; r2_v = r1_v;
    r1_d = key_down; r1_v = key_val;
    pop = (mq.size() != 0) && evt_if.evt_ready;
    has_evt = 1'b0;
    ev = '0;
    if (!m_held) begin
      if (s_d) begin
        if (m_run > 0 && s_v == m_cand) m_run++;
        else begin
          m_cand = s_v;
          m_run  = 1;
        end
      end else begin
        m_run = 0;
      end
      if (m_run == D + 1) begin
        has_evt = 1'b1; ev = {1'b1, m_cand}; m_held = 1'b1; m_run = 0;
      end
    end else begin
      if (!(s_d && s_v == m_cand)) m_run++;
      else m_run = 0;
      if (m_run == D + 1) begin
        has_evt = 1'b1; ev = {1'b0, m_cand}; m_held = 1'b0; m_run = 0;
      end
    end
    if (pop) void'(mq.pop_front());
    if (has_evt) begin
      if (mq.size() < DEPTH) mq.push_back(ev);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [4:0] h;
    h = (mq.size() != 0) ? mq[0] : 5'd0;
    chk({tag, ".valid"}, 8'(evt_if.evt_valid), 8'(mq.size() != 0));
    chk({tag, ".code"},  8'(evt_if.evt_code),  8'(h[3:0]));
    chk({tag, ".press"}, 8'(evt_if.evt_press), 8'(h[4]));
    chk({tag, ".count"}, 8'(fifo_count),       8'(mq.size()));
    chk({tag, ".ovf"},   8'(overflow),         8'(m_ovf));
  endtask

  task automatic step(input string tag, input logic [3:0] kv, input logic kd, input logic rdy);
    key_val  = kv;
    key_down = kd;
    evt_if.evt_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    key_val = 4'd0; key_down = 1'b0; evt_if.evt_ready = 1'b0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  int first_valid;

  initial begin
    reset_n = 1'b1;
    key_val = 4'd0; key_down = 1'b0; evt_if.evt_ready = 1'b0;
    #2;
    do_reset();
    check_outputs("reset");

    // 1: clean press then release of key 5, latency D+3 edges each way
    first_valid = 0;
    for (int i = 1; i <= 20; i++) begin
      step("s1p", 4'd5, 1'b1, 1'b1);
      if (first_valid == 0 && evt_if.evt_valid) first_valid = i;
    end
    chk("press_latency", 8'(first_valid), 8'(D + 3));
    first_valid = 0;
    for (int i = 1; i <= 15; i++) begin
      step("s1r", 4'd5, 1'b0, 1'b1);
      if (first_valid == 0 && evt_if.evt_valid) first_valid = i;
    end
    chk("release_latency", 8'(first_valid), 8'(D + 3));

    // 2: short glitch produces nothing
    repeat (2)  step("s2", 4'd2, 1'b1, 1'b1);
    repeat (10) step("s2", 4'd2, 1'b0, 1'b1);
    chk("glitch_count", 8'(fifo_count), 8'd0);

    // 3: code changes during press debounce
    repeat (2)  step("s3", 4'd3, 1'b1, 1'b1);
    repeat (12) step("s3", 4'd7, 1'b1, 1'b1);
    repeat (10) step("s3", 4'd7, 1'b0, 1'b1);

    // 4: release bounce while held
    repeat (10) step("s4", 4'd9, 1'b1, 1'b1);
    repeat (2)  step("s4", 4'd9, 1'b0, 1'b1);
    repeat (10) step("s4", 4'd9, 1'b1, 1'b1);
    repeat (10) step("s4", 4'd9, 1'b0, 1'b1);

    // 5: six events into a four-deep queue with no consumer
    for (int c = 1; c <= 3; c++) begin
      repeat (10) step("s5", 4'(c), 1'b1, 1'b0);
      repeat (10) step("s5", 4'(c), 1'b0, 1'b0);
    end
    chk("ovf_count", 8'(fifo_count), 8'd4);
    chk("ovf_flag", 8'(overflow), 8'd1);
    repeat (6) step("s5d", 4'd0, 1'b0, 1'b1);
    chk("ovf_sticky", 8'(overflow), 8'd1);

    // 6: asynchronous reset with events queued and key 4 still held
    do_reset();
    repeat (10) step("s6", 4'd2, 1'b1, 1'b0);
    repeat (10) step("s6", 4'd2, 1'b0, 1'b0);
    repeat (10) step("s6", 4'd4, 1'b1, 1'b0);
    step("s6", 4'd4, 1'b1, 1'b1);
    chk("pre_reset_count", 8'(fifo_count), 8'd2);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    first_valid = 0;
    for (int i = 1; i <= 12; i++) begin
      step("s6b", 4'd4, 1'b1, 1'b0);
      if (first_valid == 0 && evt_if.evt_valid) first_valid = i;
    end
    chk("post_reset_latency", 8'(first_valid), 8'(D + 3));
    chk("post_reset_code", 8'(evt_if.evt_code), 8'd4);

    // Random key activity with random consumer back-pressure
    for (int n = 0; n < 60; n++) begin
      logic [3:0] code;
      logic       down;
      int         len;
      code = 4'($urandom_range(0, 15));
      down = ($urandom_range(0, 3) != 0);
      len  = $urandom_range(1, 10);
      for (int k = 0; k < len; k++) begin
        step("rnd", code, down, 1'($urandom_range(0, 1)));
      end
    end
    repeat (20) step("drain", 4'd0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
